// File: rtl/smart_cargo_pkg.sv
// Shared definitions for the smart_cargo request path: error codes, byte layout,
// request record and the state encoding of the request queue front end.
package smart_cargo_pkg;

  localparam logic [1:0] ERRO_OK      = 2'b00;
  localparam logic [1:0] ERRO_FORMATO = 2'b01;
  localparam logic [1:0] ERRO_ANDAR   = 2'b10;
  localparam logic [1:0] ERRO_CHEIA   = 2'b11;

  localparam int ORIGEM_LSB    = 0;
  localparam int DESTINO_LSB   = 2;
  localparam int TIPO_LSB      = 4;
  localparam int RESERVADO_LSB = 6;

  localparam logic [1:0] TIPO_VAZIO = 2'b00;

  localparam logic [1:0] EST_OCIOSO   = 2'd0;
  localparam logic [1:0] EST_VALIDA   = 2'd1;
  localparam logic [1:0] EST_GRAVA    = 2'd2;
  localparam logic [1:0] EST_DESCARTA = 2'd3;

  typedef struct packed {
    logic [1:0] tipo;
    logic [1:0] destino;
    logic [1:0] origem;
  } pedido_t;

  // Checks are ordered: a malformed byte is never reported as a floor or full error.
  function automatic logic [1:0] valida_pedido(input logic [7:0] b,
                                               input int         num_andares,
                                               input logic       cheia,
                                               input logic       consome);
    logic [1:0] res;
    logic [1:0] o;
    logic [1:0] d;
    logic [1:0] t;
    logic [1:0] r;
    o = b[ORIGEM_LSB +: 2];
    d = b[DESTINO_LSB +: 2];
    t = b[TIPO_LSB +: 2];
    r = b[RESERVADO_LSB +: 2];
    if (r != 2'b00 || t == TIPO_VAZIO)
      res = ERRO_FORMATO;
    else if (int'(o) >= num_andares || int'(d) >= num_andares || o == d)
      res = ERRO_ANDAR;
    else if (cheia && !consome)
      res = ERRO_CHEIA;
    else
      res = ERRO_OK;
    return res;
  endfunction

endpackage

// File: rtl/fifo_sincrona_N.sv
// Small synchronous FIFO with combinational head; simultaneous push and pop
// on a full FIFO is allowed since the pop frees the slot being written.
module fifo_sincrona_N #(
  parameter int LARGURA      = 6,
  parameter int PROFUNDIDADE = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push_i,
  input  logic [LARGURA-1:0]              dado_i,
  input  logic                            pop_i,
  output logic [LARGURA-1:0]              dado_o,
  output logic [$clog2(PROFUNDIDADE):0]   contagem_o,
  output logic                            cheia_o,
  output logic                            vazia_o
);

  localparam int PW = $clog2(PROFUNDIDADE);

  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [PW:0]        cont_q;
  logic               push_ok;
  logic               pop_ok;

  assign vazia_o    = (cont_q == '0);
  assign cheia_o    = (cont_q == (PW+1)'(PROFUNDIDADE));
  assign contagem_o = cont_q;
  assign dado_o     = mem_q[rd_ptr_q];
  assign pop_ok     = pop_i & ~vazia_o;
  assign push_ok    = push_i & (~cheia_o | pop_ok);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cont_q   <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= dado_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cont_q <= cont_q + (PW+1)'(1);
        2'b01:   cont_q <= cont_q - (PW+1)'(1);
        default: cont_q <= cont_q;
      endcase
    end
  end

endmodule

// File: rtl/fila_pedidos_serial.sv
// Captures request bytes from the serial receiver, validates them and queues the
// accepted ones for the control unit; rejected ones are flagged and counted.
module fila_pedidos_serial
  import smart_cargo_pkg::*;
#(
  parameter int PROFUNDIDADE = 4,
  parameter int NUM_ANDARES  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          serial_pronto,
  input  logic [7:0]                    dados_serial,
  input  logic                          consome,
  output logic                          pedido_valido,
  output logic [1:0]                    origem,
  output logic [1:0]                    destino,
  output logic [1:0]                    tipo,
  output logic                          cheia,
  output logic [$clog2(PROFUNDIDADE):0] ocupacao,
  output logic                          pedido_descartado,
  output logic [1:0]                    erro_codigo,
  output logic [7:0]                    contagem_descartes
);

  logic       pronto_q;
  logic [1:0] estado_q, estado_d;
  logic [7:0] captura_q, captura_d;
  logic [1:0] erro_q, erro_d;
  logic [7:0] descartes_q, descartes_d;

  logic       borda;
  logic       fifo_push;
  logic       fifo_cheia;
  logic       fifo_vazia;
  pedido_t    cabeca;
  pedido_t    entrada;

  assign borda     = serial_pronto & ~pronto_q;
  assign fifo_push = (estado_q == EST_GRAVA);
  assign entrada   = pedido_t'(captura_q[5:0]);

  always_comb begin
    estado_d    = estado_q;
    captura_d   = captura_q;
    erro_d      = erro_q;
    descartes_d = descartes_q;
    case (estado_q)
      EST_OCIOSO: begin
        if (borda) begin
          captura_d = dados_serial;
          estado_d  = EST_VALIDA;
        end
      end
      EST_VALIDA: begin
        // A consome in this cycle pops at the same edge, so a full FIFO still has room for the write.
        erro_d   = valida_pedido(captura_q, NUM_ANDARES, fifo_cheia, consome);
        estado_d = (erro_d == ERRO_OK) ? EST_GRAVA : EST_DESCARTA;
      end
      EST_GRAVA: estado_d = EST_OCIOSO;
      EST_DESCARTA: begin
        if (descartes_q != 8'hFF) descartes_d = descartes_q + 8'd1;
        estado_d = EST_OCIOSO;
      end
      default: estado_d = EST_OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pronto_q    <= 1'b0;
      estado_q    <= EST_OCIOSO;
      captura_q   <= '0;
      erro_q      <= ERRO_OK;
      descartes_q <= '0;
    end else begin
      pronto_q    <= serial_pronto;
      estado_q    <= estado_d;
      captura_q   <= captura_d;
      erro_q      <= erro_d;
      descartes_q <= descartes_d;
    end
  end

  fifo_sincrona_N #(
    .LARGURA      (6),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (fifo_push),
    .dado_i     (entrada),
    .pop_i      (consome),
    .dado_o     (cabeca),
    .contagem_o (ocupacao),
    .cheia_o    (fifo_cheia),
    .vazia_o    (fifo_vazia)
  );

  assign pedido_valido      = ~fifo_vazia;
  assign cheia              = fifo_cheia;
  assign origem             = cabeca.origem;
  assign destino            = cabeca.destino;
  assign tipo               = cabeca.tipo;
  assign pedido_descartado  = (estado_q == EST_DESCARTA);
  assign erro_codigo        = erro_q;
  assign contagem_descartes = descartes_q;

endmodule
